// File: rtl/battle_sequencer.sv
// Battle-screen turn controller: PS/2 key edge detection, HP bookkeeping and
// frame-timed sequencing of the TITLE/MENU/ATTACK/ATK_RESULT/DODGE/WIN/LOSE phases.
module battle_sequencer #(
  parameter int         ENEMY_HP_INIT  = 400,
  parameter int         PLAYER_HP_INIT = 20,
  parameter int         HIT_DAMAGE     = 4,
  parameter int         INVULN_FRAMES  = 30,
  parameter int         RESULT_FRAMES  = 60,
  parameter int         DODGE_FRAMES   = 300,
  parameter int         ATTACK_TIMEOUT = 240,
  parameter logic [7:0] KEY_SPACE      = 8'h29,
  parameter logic [7:0] KEY_LEFT       = 8'h6B,
  parameter logic [7:0] KEY_RIGHT      = 8'h74
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [15:0] key,
  input  logic        space_pressed,
  input  logic [9:0]  damage,
  input  logic        player_hit,
  output logic [3:0]  state,
  output logic        menu_sel,
  output logic [9:0]  enemy_hp,
  output logic [9:0]  player_hp,
  output logic [9:0]  last_damage,
  output logic [7:0]  turn_count,
  output logic        invuln
);

  typedef enum logic [3:0] {
    TITLE      = 4'd0,
    MENU       = 4'd1,
    ATTACK     = 4'd2,
    ATK_RESULT = 4'd3,
    DODGE      = 4'd4,
    WIN        = 4'd5,
    LOSE       = 4'd6
  } state_t;

  localparam logic [9:0] E_INIT    = 10'(ENEMY_HP_INIT);
  localparam logic [9:0] P_INIT    = 10'(PLAYER_HP_INIT);
  localparam logic [9:0] HIT_DMG   = 10'(HIT_DAMAGE);
  localparam logic [9:0] INV_LEN   = 10'(INVULN_FRAMES);
  localparam logic [9:0] RES_LEN   = 10'(RESULT_FRAMES);
  localparam logic [9:0] DODGE_LEN = 10'(DODGE_FRAMES);
  localparam logic [9:0] ATK_TO    = 10'(ATTACK_TIMEOUT);
  localparam logic [9:0] FRAME_MAX = 10'd1023;
  localparam logic [7:0] RELEASE   = 8'hF0;

  state_t     state_q, state_d;
  logic [9:0] frame_cnt, frame_cnt_d;
  logic [9:0] inv_cnt, inv_cnt_d;
  logic       menu_sel_d, invuln_d;
  logic [9:0] enemy_hp_d, player_hp_d, last_damage_d;
  logic [7:0] turn_count_d;

  // Press history: last-cycle key conditions plus the two strobe inputs.
  logic space_c, left_c, right_c;
  logic space_q, left_q, right_q, strike_q, hit_q;
  logic space_ev, left_ev, right_ev, strike_ev, hit_ev;

  assign space_c   = (key[7:0] == KEY_SPACE) && (key[15:8] != RELEASE);
  assign left_c    = (key[7:0] == KEY_LEFT)  && (key[15:8] != RELEASE);
  assign right_c   = (key[7:0] == KEY_RIGHT) && (key[15:8] != RELEASE);
  assign space_ev  = space_c & ~space_q;
  assign left_ev   = left_c & ~left_q;
  assign right_ev  = right_c & ~right_q;
  assign strike_ev = space_pressed & ~strike_q;
  assign hit_ev    = player_hit & ~hit_q;

  assign state = state_q;

  always_comb begin
    // NOTE: every target gets a hold value first so no path can infer a latch.
    state_d       = state_q;
    menu_sel_d    = menu_sel;
    enemy_hp_d    = enemy_hp;
    player_hp_d   = player_hp;
    last_damage_d = last_damage;
    turn_count_d  = turn_count;
    invuln_d      = invuln;
    inv_cnt_d     = inv_cnt;
    frame_cnt_d   = frame_cnt;

    // Immunity window counts down in frames; an accepted hit below reloads it.
    if (frame_tick && inv_cnt != '0) begin
      inv_cnt_d = inv_cnt - 10'd1;
      if (inv_cnt == 10'd1) invuln_d = 1'b0;
    end

    case (state_q)
      TITLE: if (space_ev) state_d = MENU;
      MENU: begin
        if (space_ev) begin
          if (!menu_sel) state_d = ATTACK;
          else if (({2'b00, enemy_hp} << 2) <= {2'b00, E_INIT}) state_d = WIN;
          else begin
            state_d       = DODGE;
            last_damage_d = '0;
          end
        end else if (left_ev ^ right_ev) begin
          menu_sel_d = ~menu_sel;
        end
      end
      ATTACK: begin
        if (strike_ev) begin
          last_damage_d = damage;
          enemy_hp_d    = (damage >= enemy_hp) ? '0 : enemy_hp - damage;
          state_d       = ATK_RESULT;
        end else if (frame_cnt >= ATK_TO) begin
          last_damage_d = '0;
          state_d       = ATK_RESULT;
        end
      end
      ATK_RESULT: if (frame_cnt >= RES_LEN) state_d = (enemy_hp == '0) ? WIN : DODGE;
      DODGE: begin
        if (hit_ev && !invuln) begin
          player_hp_d = (player_hp > HIT_DMG) ? player_hp - HIT_DMG : '0;
          invuln_d    = 1'b1;
          inv_cnt_d   = INV_LEN;
        end
        // The hit is folded in before the timer so a fatal hit always ends in LOSE.
        if (player_hp_d == '0) state_d = LOSE;
        else if (frame_cnt >= DODGE_LEN) begin
          state_d      = MENU;
          turn_count_d = turn_count + 8'd1;
          invuln_d     = 1'b0;
          inv_cnt_d    = '0;
        end
      end
      WIN, LOSE: begin
        if (space_ev) begin
          state_d       = TITLE;
          enemy_hp_d    = E_INIT;
          player_hp_d   = P_INIT;
          turn_count_d  = '0;
          last_damage_d = '0;
          menu_sel_d    = 1'b0;
        end
      end
      default: state_d = TITLE;
    endcase

    if (state_d != state_q) frame_cnt_d = '0;
    else if (frame_tick && frame_cnt != FRAME_MAX) frame_cnt_d = frame_cnt + 10'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= TITLE;
      menu_sel    <= 1'b0;
      enemy_hp    <= E_INIT;
      player_hp   <= P_INIT;
      last_damage <= '0;
      turn_count  <= '0;
      invuln      <= 1'b0;
      inv_cnt     <= '0;
      frame_cnt   <= '0;
      space_q     <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      strike_q    <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      menu_sel    <= menu_sel_d;
      enemy_hp    <= enemy_hp_d;
      player_hp   <= player_hp_d;
      last_damage <= last_damage_d;
      turn_count  <= turn_count_d;
      invuln      <= invuln_d;
      inv_cnt     <= inv_cnt_d;
      frame_cnt   <= frame_cnt_d;
      space_q     <= space_c;
      left_q      <= left_c;
      right_q     <= right_c;
      strike_q    <= space_pressed;
      hit_q       <= player_hit;
    end
  end

endmodule

// File: tb/tb_battle_sequencer.sv
// Self-checking bench for battle_sequencer: directed table and corner sequences,
// then random stimulus compared every cycle against a phase-level reference model.
`timescale 1ns/1ps
module tb_battle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [15:0] key;
  logic        space_pressed;
  logic [9:0]  damage;
  logic        player_hit;
  logic [3:0]  state;
  logic        menu_sel;
  logic [9:0]  enemy_hp;
  logic [9:0]  player_hp;
  logic [9:0]  last_damage;
  logic [7:0]  turn_count;
  logic        invuln;

  int n_checks = 0;
  int n_pass   = 0;

  battle_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .key           (key),
    .space_pressed (space_pressed),
    .damage        (damage),
    .player_hit    (player_hit),
    .state         (state),
    .menu_sel      (menu_sel),
    .enemy_hp      (enemy_hp),
    .player_hp     (player_hp),
    .last_damage   (last_damage),
    .turn_count    (turn_count),
    .invuln        (invuln)
  );

  always #5 clk = ~clk;

  // Reference model: phases as plain integers, HP math in int arithmetic.
  int m_state = 0, m_sel = 0, m_ehp = 400, m_php = 20, m_ld = 0, m_tc = 0;
  int m_inv = 0, m_inv_left = 0, m_frames = 0;
  bit m_ps = 0, m_pl = 0, m_pr = 0, m_psp = 0, m_phit = 0;

  task automatic model_update();
    bit cs, cl, cr, es, el, er, strike, hit_rise;
    int nxt, old_inv;
    cs = (key[7:0] == 8'h29) && (key[15:8] != 8'hF0);
    cl = (key[7:0] == 8'h6B) && (key[15:8] != 8'hF0);
    cr = (key[7:0] == 8'h74) && (key[15:8] != 8'hF0);
    es = cs && !m_ps;
    el = cl && !m_pl;
    er = cr && !m_pr;
    strike   = space_pressed && !m_psp;
    hit_rise = player_hit && !m_phit;
    m_ps = cs; m_pl = cl; m_pr = cr; m_psp = space_pressed; m_phit = player_hit;
    if (reset) begin
      m_state = 0; m_sel = 0; m_ehp = 400; m_php = 20; m_ld = 0; m_tc = 0;
      m_inv = 0; m_inv_left = 0; m_frames = 0;
      m_ps = 0; m_pl = 0; m_pr = 0; m_psp = 0; m_phit = 0;
      return;
    end
    nxt = m_state;
    old_inv = m_inv;
    if (frame_tick && m_inv_left > 0) begin
      m_inv_left = m_inv_left - 1;
      if (m_inv_left == 0) m_inv = 0;
    end
    case (m_state)
      0: if (es) nxt = 1;
      1: begin
        if (es) begin
          if (m_sel == 0) nxt = 2;
          else if (m_ehp * 4 <= 400) nxt = 5;
          else begin nxt = 4; m_ld = 0; end
        end else if (el != er) m_sel = 1 - m_sel;
      end
      2: begin
        if (strike) begin
          m_ld  = int'(damage);
          m_ehp = (int'(damage) >= m_ehp) ? 0 : m_ehp - int'(damage);
          nxt   = 3;
        end else if (m_frames >= 240) begin
          m_ld = 0;
          nxt  = 3;
        end
      end
      3: if (m_frames >= 60) nxt = (m_ehp == 0) ? 5 : 4;
      4: begin
        if (hit_rise && old_inv == 0) begin
          m_php = (m_php > 4) ? m_php - 4 : 0;
          m_inv = 1;
          m_inv_left = 30;
        end
        if (m_php == 0) nxt = 6;
        else if (m_frames >= 300) begin
          nxt = 1; m_tc = (m_tc + 1) % 256; m_inv = 0; m_inv_left = 0;
        end
      end
      5, 6: if (es) begin
        nxt = 0; m_ehp = 400; m_php = 20; m_tc = 0; m_ld = 0; m_sel = 0;
      end
      default: nxt = 0;
    endcase
    if (nxt != m_state) m_frames = 0;
    else if (frame_tick) m_frames = (m_frames < 1023) ? m_frames + 1 : 1023;
    m_state = nxt;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // A negative expectation means "not checked here".
  task automatic check_outs(input string tag, input int st, input int sel, input int ehp,
                            input int php, input int ld, input int tc, input int inv);
    if (st  >= 0) check({tag, ".state"},       int'(state),       st);
    if (sel >= 0) check({tag, ".menu_sel"},    int'(menu_sel),    sel);
    if (ehp >= 0) check({tag, ".enemy_hp"},    int'(enemy_hp),    ehp);
    if (php >= 0) check({tag, ".player_hp"},   int'(player_hp),   php);
    if (ld  >= 0) check({tag, ".last_damage"}, int'(last_damage), ld);
    if (tc  >= 0) check({tag, ".turn_count"},  int'(turn_count),  tc);
    if (inv >= 0) check({tag, ".invuln"},      int'(invuln),      inv);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic press(input logic [7:0] code);
    key = {8'h00, code}; step();
    key = {8'hF0, code}; step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic hit_pulse();
    player_hit = 1'b1; step();
    player_hit = 1'b0; step();
  endtask

  task automatic strike(input logic [9:0] d);
    damage = d; space_pressed = 1'b1; step();
    space_pressed = 1'b0; step();
  endtask

  typedef struct {
    logic [15:0] key;
    int          st;
    int          sel;
  } vec_t;

  vec_t tbl [15];
  int   hit_hp [7];
  logic [15:0] keys [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{16'hF029, 1, 0};
    tbl[1]  = '{16'h0074, 1, 1};
    tbl[2]  = '{16'h0074, 1, 1};
    tbl[3]  = '{16'hF074, 1, 1};
    tbl[4]  = '{16'h006B, 1, 0};
    tbl[5]  = '{16'hF06B, 1, 0};
    tbl[6]  = '{16'h0074, 1, 1};
    tbl[7]  = '{16'hF074, 1, 1};
    tbl[8]  = '{16'h0074, 1, 0};
    tbl[9]  = '{16'h001C, 1, 0};
    tbl[10] = '{16'h006B, 1, 1};
    tbl[11] = '{16'hF06B, 1, 1};
    tbl[12] = '{16'h006B, 1, 0};
    tbl[13] = '{16'h0000, 1, 0};
    tbl[14] = '{16'h0029, 2, 0};
    hit_hp = '{16, 16, 16, 12, 12, 12, 8};
    keys = '{16'h0029, 16'hF029, 16'h006B, 16'hF06B, 16'h0074, 16'hF074, 16'h0000, 16'h6B74};

    reset = 1'b1; frame_tick = 1'b0; key = 16'h0000;
    space_pressed = 1'b0; damage = '0; player_hit = 1'b0;
    step(); step();
    reset = 1'b0;
    check_outs("reset", 0, 0, 400, 20, 0, 0, 0);

    // Space from TITLE, then hold it: exactly one transition.
    key = 16'h0029; step();
    check_outs("title_space", 1, 0, 400, 20, -1, -1, -1);
    for (int i = 0; i < 1000; i++) step();
    check_outs("hold_space", 1, 0, 400, 20, -1, -1, -1);

    for (int i = 0; i < 15; i++) begin
      key = tbl[i].key; step();
      check_outs($sformatf("tbl%0d", i), tbl[i].st, tbl[i].sel, -1, -1, -1, -1, -1);
    end
    key = 16'hF029; step();

    strike(10'd150);
    check_outs("strike150", 3, -1, 250, 20, 150, 0, 0);
    frames(59);
    check_outs("result_59", 3, -1, -1, -1, -1, -1, -1);
    frames(1);
    check_outs("result_60", 4, -1, 250, 20, 150, 0, 0);

    // Hits every 10 frames; only those 30 frames apart get through.
    for (int h = 0; h < 7; h++) begin
      if (h > 0) frames(10);
      hit_pulse();
      check_outs($sformatf("hit%0d", h), 4, -1, -1, hit_hp[h], -1, -1, 1);
    end
    frames(239);
    check_outs("dodge_299", 4, -1, -1, 8, -1, 0, -1);
    frames(1);
    check_outs("dodge_300", 1, -1, 250, 8, -1, 1, 0);

    press(8'h29);
    check_outs("fight2", 2, 0, -1, -1, -1, -1, -1);
    strike(10'd300);
    check_outs("overkill", 3, -1, 0, -1, 300, -1, -1);
    frames(60);
    check_outs("win", 5, -1, 0, -1, -1, -1, -1);
    press(8'h29);
    check_outs("restart", 0, 0, 400, 20, 0, 0, 0);

    press(8'h29); press(8'h29);
    strike(10'd299);
    check_outs("ehp101", 3, -1, 101, -1, 299, -1, -1);
    frames(60); frames(300);
    check_outs("turn1", 1, 0, -1, -1, -1, 1, -1);
    press(8'h29);
    frames(239);
    check_outs("atk_239", 2, -1, 101, -1, 299, -1, -1);
    frames(1);
    check_outs("atk_timeout", 3, -1, 101, -1, 0, -1, -1);
    frames(60); frames(300);
    check_outs("turn2", 1, 0, -1, -1, -1, 2, -1);
    press(8'h74);
    check_outs("sel_mercy", 1, 1, -1, -1, -1, -1, -1);
    press(8'h29);
    check_outs("mercy_101", 4, 1, 101, -1, 0, -1, -1);
    frames(300);
    check_outs("turn3", 1, 1, -1, -1, -1, 3, -1);
    press(8'h6B);
    press(8'h29);
    strike(10'd1);
    check_outs("ehp100", 3, -1, 100, -1, 1, -1, -1);
    frames(60); frames(300);
    check_outs("turn4", 1, 0, 100, -1, -1, 4, -1);
    press(8'h74);
    press(8'h29);
    check_outs("mercy_100", 5, 1, 100, -1, 1, 4, -1);

    // Fatal hit landing on the same cycle as the dodge timer expiry.
    press(8'h29);
    press(8'h29); press(8'h29);
    strike(10'd1);
    frames(60);
    hit_pulse();
    for (int h = 0; h < 3; h++) begin frames(30); hit_pulse(); end
    check_outs("php4", 4, -1, 399, 4, -1, 0, -1);
    frames(209);
    check_outs("expiry_299", 4, -1, -1, 4, -1, 0, -1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    player_hit = 1'b1; step(); player_hit = 1'b0;
    check_outs("hit_at_expiry", 6, -1, -1, 0, -1, 0, -1);

    // Reset in DODGE together with a hit and a space press.
    press(8'h29);
    press(8'h29); press(8'h29);
    strike(10'd10);
    frames(60);
    hit_pulse();
    check_outs("pre_reset", 4, 0, 390, 16, 10, 0, 1);
    key = 16'h0029; player_hit = 1'b1; reset = 1'b1; step();
    reset = 1'b0; player_hit = 1'b0;
    check_outs("reset_mid", 0, 0, 400, 20, 0, 0, 0);
    key = 16'hF029; step();

    // Random stimulus against the reference model.
    for (int c = 0; c < 20000 && (n_checks - n_pass) < 20; c++) begin
      reset = ($urandom_range(0, 2999) == 0);
      frame_tick = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0)
        key = ($urandom_range(0, 9) == 0) ? 16'($urandom) : keys[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) space_pressed = ~space_pressed;
      damage = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 120));
      if ($urandom_range(0, 5) == 0) player_hit = ~player_hit;
      step();
      check_outs("rand", m_state, m_sel, m_ehp, m_php, m_ld, m_tc, m_inv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
